// File: rtl/pwm_duty_ramp_pkg.sv
// Shared definitions for the PWM duty-ramp front-end: default widths matching
// the PWM core and the ramp controller state encoding.
package pwm_duty_ramp_pkg;

  localparam int DEF_WIDTH_PERIOD = 16;
  localparam int DEF_WIDTH_DUTY   = 16;
  localparam int DEF_WIDTH_STEP   = 8;
  localparam int DEF_WIDTH_DIV    = 8;
  localparam int DEF_INIT_PERIOD  = 1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RAMP  = 2'd2
  } ramp_state_e;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Configuration request channel of the duty-ramp block: valid/ready handshake
// carrying a new period, a target duty and the ramp rate.
interface pwm_duty_ramp_if
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD,
  parameter int WIDTH_DUTY   = DEF_WIDTH_DUTY,
  parameter int WIDTH_STEP   = DEF_WIDTH_STEP,
  parameter int WIDTH_DIV    = DEF_WIDTH_DIV
) ();

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [WIDTH_PERIOD-1:0] cfg_period;
  logic [WIDTH_DUTY-1:0]   cfg_duty;
  logic [WIDTH_STEP-1:0]   cfg_step;
  logic [WIDTH_DIV-1:0]    cfg_div;

  modport master (
    output cfg_valid,
    output cfg_period,
    output cfg_duty,
    output cfg_step,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_period,
    input  cfg_duty,
    input  cfg_step,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/pwm_phase_tracker.sv
// Mirror of the PWM core counter; flags the last count of every period so other
// blocks can change settings exactly where the core wraps to zero.
module pwm_phase_tracker
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WIDTH_PERIOD-1:0] period,
  output logic                    bnd
);

  logic [WIDTH_PERIOD-1:0] ph;
  logic [WIDTH_PERIOD-1:0] last_count;

  // Truncated subtraction keeps period 0 wrapping at the all-ones count, as the core does.
  assign last_count = period - WIDTH_PERIOD'(1);
  assign bnd        = (ph >= last_count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= '0;
    end else if (bnd) begin
      ph <= '0;
    end else begin
      ph <= ph + WIDTH_PERIOD'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Configuration front-end for the PWM core: applies a new period and walks the
// duty toward a target in steps, touching outputs only at period boundaries.
module pwm_duty_ramp
  import pwm_duty_ramp_pkg::*;
#(
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD,
  parameter int WIDTH_DUTY   = DEF_WIDTH_DUTY,
  parameter int WIDTH_STEP   = DEF_WIDTH_STEP,
  parameter int WIDTH_DIV    = DEF_WIDTH_DIV,
  parameter int INIT_PERIOD  = DEF_INIT_PERIOD
) (
  input  logic                    clk,
  input  logic                    reset_n,
  pwm_duty_ramp_if.slave          cfg,
  output logic [WIDTH_PERIOD-1:0] period,
  output logic [WIDTH_DUTY-1:0]   duty,
  output logic                    busy,
  output logic                    ramp_done
);

  ramp_state_e state;
  ramp_state_e state_next;

  logic [WIDTH_DUTY-1:0]   target;
  logic [WIDTH_STEP-1:0]   step_r;
  logic [WIDTH_DIV-1:0]    div_r;
  logic [WIDTH_DIV-1:0]    div_cnt;
  logic [WIDTH_PERIOD-1:0] pend_period;

  logic                    bnd;
  logic                    accept;
  logic                    div_hit;
  logic                    step_evt;
  logic                    done_evt;
  logic [WIDTH_DUTY-1:0]   duty_next;

  logic [WIDTH_DUTY:0]     duty_x;
  logic [WIDTH_DUTY:0]     target_x;
  logic [WIDTH_DUTY:0]     step_x;
  logic [WIDTH_DUTY:0]     sum_x;
  logic [WIDTH_DUTY:0]     gap_x;
  logic [WIDTH_DIV:0]      cnt_inc;
  logic [WIDTH_DIV:0]      div_eff;

  pwm_phase_tracker #(
    .WIDTH_PERIOD (WIDTH_PERIOD)
  ) u_tracker (
    .clk     (clk),
    .reset_n (reset_n),
    .period  (period),
    .bnd     (bnd)
  );

  assign accept = cfg.cfg_valid && (state == IDLE);

  // A divider of 0 behaves as 1, so a step is due on every boundary.
  assign cnt_inc = {1'b0, div_cnt} + (WIDTH_DIV+1)'(1);
  assign div_eff = (div_r == '0) ? (WIDTH_DIV+1)'(1) : {1'b0, div_r};
  assign div_hit = (cnt_inc >= div_eff);

  assign step_evt = bnd && ((state == APPLY) || ((state == RAMP) && div_hit));
  assign done_evt = step_evt && (duty_next == target);

  // One extra bit on every operand so neither direction can wrap past the target.
  always_comb begin
    duty_x    = {1'b0, duty};
    target_x  = {1'b0, target};
    step_x    = (WIDTH_DUTY+1)'(step_r);
    sum_x     = duty_x + step_x;
    gap_x     = duty_x - target_x;
    duty_next = target;
    if (step_r != '0) begin
      if (duty < target) begin
        duty_next = (sum_x >= target_x) ? target : sum_x[WIDTH_DUTY-1:0];
      end else if (duty > target) begin
        duty_next = (gap_x <= step_x) ? target : (duty - WIDTH_DUTY'(step_r));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   if (bnd) state_next = done_evt ? IDLE : RAMP;
      RAMP:    if (done_evt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg.cfg_ready = 1'b0;
    busy          = 1'b1;
    if (state == IDLE) begin
      cfg.cfg_ready = 1'b1;
      busy          = 1'b0;
    end
  end

  // Period and duty move on the edge where the mirror counter returns to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period      <= WIDTH_PERIOD'(INIT_PERIOD);
      duty        <= '0;
      target      <= '0;
      step_r      <= '0;
      div_r       <= '0;
      div_cnt     <= '0;
      pend_period <= '0;
      ramp_done   <= 1'b0;
    end else begin
      ramp_done <= done_evt;
      if (accept) begin
        target      <= cfg.cfg_duty;
        step_r      <= cfg.cfg_step;
        div_r       <= cfg.cfg_div;
        pend_period <= cfg.cfg_period;
      end
      if (accept || step_evt) begin
        div_cnt <= '0;
      end else if ((state == RAMP) && bnd) begin
        div_cnt <= div_cnt + WIDTH_DIV'(1);
      end
      if (step_evt) begin
        duty <= duty_next;
      end
      if ((state == APPLY) && bnd) begin
        period <= pend_period;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: cycle-level behavioural model plus a
// completion scoreboard fed at accept time and drained on ramp_done.
module tb_pwm_duty_ramp;
  import pwm_duty_ramp_pkg::*;

  localparam int W_P = 16;
  localparam int W_D = 16;
  localparam int W_S = 8;
  localparam int W_V = 8;
  localparam int INIT_P = 1000;

  typedef struct {
    int duty;
    int period;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [W_P-1:0] period;
  logic [W_D-1:0] duty;
  logic busy;
  logic ramp_done;

  int checks = 0;
  int failures = 0;

  int m_ph = 0;
  int m_period = INIT_P;
  int m_duty = 0;
  int m_target = 0;
  int m_step = 0;
  int m_div = 1;
  int m_pend = 0;
  int m_k = 0;
  bit m_busy = 0;
  bit m_applied = 0;
  bit m_done = 0;
  exp_t sb_q[$];

  pwm_duty_ramp_if #(.WIDTH_PERIOD(W_P), .WIDTH_DUTY(W_D), .WIDTH_STEP(W_S), .WIDTH_DIV(W_V)) cfg_if ();

  pwm_duty_ramp #(
    .WIDTH_PERIOD (W_P),
    .WIDTH_DUTY   (W_D),
    .WIDTH_STEP   (W_S),
    .WIDTH_DIV    (W_V),
    .INIT_PERIOD  (INIT_P)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg       (cfg_if.slave),
    .period    (period),
    .duty      (duty),
    .busy      (busy),
    .ramp_done (ramp_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at %0t: wait bound expired", name, $time);
  endtask

  function automatic int stepToward(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (cur < tgt) return (cur + stp > tgt) ? tgt : cur + stp;
    if (cur > tgt) return (cur - stp < tgt) ? tgt : cur - stp;
    return tgt;
  endfunction

  // Reference model: boundaries are counted from the one that applies the period;
  // a step lands on every boundary whose index is a multiple of the divider.
  initial forever begin
    int last;
    bit bnd_now;
    bit done_now;
    @(posedge clk);
    if (!reset_n) begin
      m_ph = 0; m_period = INIT_P; m_duty = 0; m_busy = 0; m_applied = 0; m_done = 0;
      sb_q.delete();
    end else begin
      last = (m_period + 65535) % 65536;
      bnd_now = (m_ph >= last);
      done_now = 0;
      if (m_busy && bnd_now) begin
        if (!m_applied) begin
          m_period = m_pend;
          m_applied = 1;
          m_k = 0;
        end else begin
          m_k++;
        end
        if (m_k % m_div == 0) begin
          m_duty = stepToward(m_duty, m_target, m_step);
          if (m_duty == m_target) begin
            m_busy = 0;
            done_now = 1;
          end
        end
      end
      m_ph = bnd_now ? 0 : m_ph + 1;
      if (!m_busy && !done_now && cfg_if.cfg_valid) begin
        m_target = int'(cfg_if.cfg_duty);
        m_step = int'(cfg_if.cfg_step);
        m_div = (cfg_if.cfg_div == 0) ? 1 : int'(cfg_if.cfg_div);
        m_pend = int'(cfg_if.cfg_period);
        m_busy = 1;
        m_applied = 0;
        sb_q.push_back('{duty: m_target, period: m_pend});
      end
      m_done = done_now;
    end
  end

  // Cycle checker: every observable output and the mirror counter against the model.
  initial forever begin
    @(negedge clk);
    checkOutput("period", int'(period), m_period);
    checkOutput("duty", int'(duty), m_duty);
    checkOutput("cfg_ready", int'(cfg_if.cfg_ready), int'(!m_busy));
    checkOutput("busy", int'(busy), int'(m_busy));
    checkOutput("ramp_done", int'(ramp_done), int'(m_done));
    checkOutput("ph", int'(dut.u_tracker.ph), m_ph);
  end

  // Scoreboard monitor: each completion must land on the oldest accepted request.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_n && ramp_done) begin
      if (sb_q.size() == 0) begin
        timeoutFail("sb_underflow");
      end else begin
        e = sb_q.pop_front();
        checkOutput("sb_duty", int'(duty), e.duty);
        checkOutput("sb_period", int'(period), e.period);
      end
    end
  end

  task automatic applyStimulus(input int p, input int d, input int s, input int dv, input bit align);
    int n;
    @(negedge clk);
    if (align) begin
      n = 0;
      while (m_ph != (m_period + 65535) % 65536 && n < 70000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 70000) timeoutFail("align");
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_period = W_P'(p);
    cfg_if.cfg_duty = W_D'(d);
    cfg_if.cfg_step = W_S'(s);
    cfg_if.cfg_div = W_V'(dv);
    n = 0;
    while (!cfg_if.cfg_ready && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 70000) timeoutFail("accept");
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((m_busy || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeoutFail("wait_idle");
  endtask

  initial begin
    int n;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_duty = '0;
    cfg_if.cfg_step = '0;
    cfg_if.cfg_div = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] reset released, idling over two default periods");
    repeat (2050) @(negedge clk);

    $display("[TB] ramp up and jump down");
    applyStimulus(10, 7, 3, 2, 0);
    waitIdle(3000);
    applyStimulus(10, 0, 0, 5, 0);
    waitIdle(200);

    $display("[TB] period 1 ramp");
    applyStimulus(1, 5, 2, 1, 0);
    waitIdle(200);

    $display("[TB] collisions");
    applyStimulus(10, 9, 4, 1, 1);
    waitIdle(500);
    applyStimulus(6, 20, 5, 1, 0);
    applyStimulus(8, 3, 7, 2, 0);
    waitIdle(1000);

    $display("[TB] randomized requests");
    for (int i = 0; i < 8; i++) begin
      applyStimulus($urandom_range(1, 12), $urandom_range(0, 40), $urandom_range(0, 6),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0) waitIdle(20000);
    end
    waitIdle(20000);

    $display("[TB] reset mid-ramp");
    applyStimulus(10, 0, 0, 1, 0);
    waitIdle(200);
    applyStimulus(10, 20, 2, 1, 0);
    n = 0;
    while (m_duty != 4 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeoutFail("reach_duty4");
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_period", int'(period), INIT_P);
    checkOutput("async_duty", int'(duty), 0);
    checkOutput("async_ready", int'(cfg_if.cfg_ready), 1);
    checkOutput("async_busy", int'(busy), 0);
    checkOutput("async_done", int'(ramp_done), 0);
    checkOutput("async_ph", int'(dut.u_tracker.ph), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(10, 7, 3, 2, 0);
    waitIdle(3000);

    $display("[TB] period 0 wraps at full count");
    applyStimulus(0, 3, 0, 1, 0);
    waitIdle(200);
    applyStimulus(5, 6, 0, 1, 0);
    waitIdle(70000);
    repeat (20) @(negedge clk);

    checkOutput("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
